// File: rtl/fifo_burst_arbiter_if.sv
// Requester, FIFO-write and status signals of the burst arbiter, bundled
// so the arbiter and its environment share one port list.
interface fifo_burst_arbiter_if #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int MAX_BURST_SIZE = 16
);
    localparam int LEN_W = $clog2(MAX_BURST_SIZE + 1);
    localparam int GID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*LEN_W-1:0]      req_len;
    logic [NUM_REQ-1:0]            req_grant;
    logic [NUM_REQ-1:0]            beat_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] beat_data;
    logic [NUM_REQ-1:0]            beat_ready;
    logic [ADDR_WIDTH:0]           fifo_free;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic [GID_W-1:0]              grant_id;
    logic                          busy;
    logic                          len_err;

    // Arbiter side.
    modport slave (
        input  req_valid, req_len, beat_valid, beat_data, fifo_free,
        output req_grant, beat_ready, fifo_wr_en, fifo_wr_data, grant_id, busy, len_err
    );

    // Requester / FIFO side.
    modport master (
        output req_valid, req_len, beat_valid, beat_data, fifo_free,
        input  req_grant, beat_ready, fifo_wr_en, fifo_wr_data, grant_id, busy, len_err
    );
endinterface

// File: rtl/fifo_burst_arbiter.sv
// Round-robin burst arbiter feeding a shared FIFO write port; a burst is
// granted only once the FIFO has room for every one of its beats.
module fifo_burst_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int MAX_BURST_SIZE = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_burst_arbiter_if.slave bus
);
    localparam int LEN_W  = $clog2(MAX_BURST_SIZE + 1);
    localparam int GID_W  = $clog2(NUM_REQ);
    localparam int FREE_W = ADDR_WIDTH + 1;
    localparam int CMP_W  = (LEN_W > FREE_W) ? LEN_W : FREE_W;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [GID_W-1:0]   r_last_winner;
    logic [GID_W-1:0]   w_last_winner_next;
    logic [GID_W-1:0]   r_grant_id;
    logic [GID_W-1:0]   w_grant_id_next;
    logic [LEN_W-1:0]   r_remaining;
    logic [LEN_W-1:0]   w_remaining_next;
    logic [NUM_REQ-1:0] r_req_grant;
    logic [NUM_REQ-1:0] w_req_grant_next;
    logic               r_len_err;
    logic               w_len_err_next;

    logic [LEN_W-1:0]      w_len   [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_data  [NUM_REQ];
    logic [GID_W-1:0]      w_idx   [NUM_REQ];
    logic [NUM_REQ-1:0]    w_beat_ready;

    logic               w_cand_found;
    logic [GID_W-1:0]   w_cand;
    logic [LEN_W-1:0]   w_cand_len;
    logic               w_len_legal;
    logic               w_len_fits;
    logic               w_beat;

    // w_idx[k] is the k-th requester in priority order, starting after the last winner.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_len[gi]        = bus.req_len[gi*LEN_W +: LEN_W];
            assign w_data[gi]       = bus.beat_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_idx[gi]        = GID_W'((int'(r_last_winner) + gi + 1) % NUM_REQ);
            assign w_beat_ready[gi] = (r_state == XFER) && (r_grant_id == GID_W'(gi));
        end
    endgenerate

    always_comb begin
        w_cand_found = 1'b0;
        w_cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_cand_found && bus.req_valid[w_idx[k]]) begin
                w_cand_found = 1'b1;
                w_cand       = w_idx[k];
            end
        end
    end

    assign w_cand_len  = w_len[w_cand];
    assign w_len_legal = (w_cand_len != '0) && (w_cand_len <= LEN_W'(MAX_BURST_SIZE));
    assign w_len_fits  = CMP_W'(w_cand_len) <= CMP_W'(bus.fifo_free);
    assign w_beat      = (r_state == XFER) && bus.beat_valid[r_grant_id];

    // No arbitration in the cycle a grant pulse is visible: the granted requester
    // only drops req_valid after seeing the pulse, so it must not be re-picked.
    always_comb begin
        w_state_next       = r_state;
        w_last_winner_next = r_last_winner;
        w_grant_id_next    = r_grant_id;
        w_remaining_next   = r_remaining;
        w_req_grant_next   = '0;
        w_len_err_next     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cand_found && (r_req_grant == '0)) begin
                    if (!w_len_legal) begin
                        w_req_grant_next[w_cand] = 1'b1;
                        w_len_err_next           = 1'b1;
                        w_last_winner_next       = w_cand;
                    end else if (w_len_fits) begin
                        w_req_grant_next[w_cand] = 1'b1;
                        w_grant_id_next          = w_cand;
                        w_remaining_next         = w_cand_len;
                        w_state_next             = XFER;
                    end
                end
            end
            XFER: begin
                if (w_beat) begin
                    w_remaining_next = r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        w_state_next       = IDLE;
                        w_last_winner_next = r_grant_id;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_last_winner <= GID_W'(NUM_REQ - 1);
            r_grant_id    <= '0;
            r_remaining   <= '0;
            r_req_grant   <= '0;
            r_len_err     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_last_winner <= w_last_winner_next;
            r_grant_id    <= w_grant_id_next;
            r_remaining   <= w_remaining_next;
            r_req_grant   <= w_req_grant_next;
            r_len_err     <= w_len_err_next;
        end
    end

    assign bus.req_grant    = r_req_grant;
    assign bus.len_err      = r_len_err;
    assign bus.grant_id     = r_grant_id;
    assign bus.busy         = (r_state == XFER);
    assign bus.beat_ready   = w_beat_ready;
    assign bus.fifo_wr_en   = w_beat;
    assign bus.fifo_wr_data = (r_state == XFER) ? w_data[r_grant_id] : '0;
endmodule
